// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target block.
package spi_target_pkg;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    localparam int unsigned BITS_PER_BYTE = 8;
    localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchroniser with a third flop for rise/fall edge detection.
module spi_target_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {3{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign dout = sync_q[1];
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with TX holding register and RX storage.
// Define SPI_TARGET_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO; otherwise a single RX register.
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = DEFAULT_IDLE_BYTE
`ifdef SPI_TARGET_RX_FIFO_EN
    ,
    parameter int unsigned RX_DEPTH = 4
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       overrun,
    output logic       underrun
);

    localparam int unsigned CNT_W = $clog2(BITS_PER_BYTE);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic unused_sclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_target_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(spi_sclk),
        .dout(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_target_sync #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .din(spi_cs_n),
        .dout(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_target_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(spi_mosi),
        .dout(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [6:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             miso_q, miso_d, oe_q, oe_d;
    logic             underrun_q, underrun_d, overrun_q;
    logic             tx_load, rx_push, rx_pop, rx_full, push_ok;
    logic [7:0]       load_byte, rx_byte;

    assign load_byte = hold_full_q ? hold_q : IDLE_BYTE;
    assign rx_byte   = {rx_shift_q, mosi_s};
    assign rx_pop    = rx_valid && rx_ready;
    assign push_ok   = rx_push && (!rx_full || rx_pop);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        tx_load     = 1'b0;
        rx_push     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    tx_load   = 1'b1;
                    miso_d    = load_byte[7];
                    oe_d      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // CS release wins over any coincident clock edge.
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                    oe_d    = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(BITS_PER_BYTE - 1)) begin
                        rx_push = 1'b1;
                        tx_load = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        miso_d     = tx_shift_q[6];
                    end else begin
                        miso_d = tx_shift_q[7];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        underrun_d = tx_load && !hold_full_q;
        if (tx_load) begin
            tx_shift_d = load_byte;
        end

        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (tx_load) begin
            hold_full_d = 1'b0;
        end
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            underrun_q  <= underrun_d;
            overrun_q   <= rx_push && rx_full && !rx_pop;
        end
    end

`ifdef SPI_TARGET_RX_FIFO_EN
    localparam int unsigned PTR_W = $clog2(RX_DEPTH);

    logic [7:0]       mem_q [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;

    assign rx_full  = count_q == (PTR_W + 1)'(RX_DEPTH);
    assign rx_valid = count_q != '0;
    assign rx_data  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < RX_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= rx_byte;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rx_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !rx_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push_ok && rx_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end
`else
    logic [7:0] rx_hold_q;
    logic       rx_hold_valid_q;

    assign rx_full  = rx_hold_valid_q;
    assign rx_valid = rx_hold_valid_q;
    assign rx_data  = rx_hold_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_hold_q       <= '0;
            rx_hold_valid_q <= 1'b0;
        end else if (push_ok) begin
            rx_hold_q       <= rx_byte;
            rx_hold_valid_q <= 1'b1;
        end else if (rx_pop) begin
            rx_hold_valid_q <= 1'b0;
        end
    end
`endif

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign tx_ready    = !hold_full_q;
    assign busy        = state_q == ST_ACTIVE;
    assign overrun     = overrun_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: drives a mode-0 host and checks MISO, RX and status pulses.
`timescale 1ns / 1ps
module tb_spi_target;

    localparam int H = 6;  // SCLK half period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       busy, overrun, underrun;

    spi_target dut (
        .clk(clk), .reset(reset),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .overrun(overrun), .underrun(underrun)
    );

    always #21 clk = ~clk;

    int         n_tests = 0;
    int         n_fail = 0;
    int         ov_cnt = 0;
    int         ur_cnt = 0;
    int         ur_snap = 0;
    logic [7:0] rx_q[$];
    logic [7:0] miso_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (overrun) ov_cnt++;
            if (underrun) ur_cnt++;
            if (rx_valid && rx_ready) begin
                if (rx_q.size() != 0) check("rx_data", rx_data, rx_q.pop_front());
                else check("rx_unexpected", rx_q.size() != 0, 1);
            end
        end
    end

    task automatic write_tx(input logic [7:0] b);
        int n = 0;
        while (!tx_ready && n < 100) begin
            tick(1);
            n++;
        end
        check("tx_ready_wait", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic cs_start();
        spi_cs_n = 1'b0;
        tick(H);
    endtask

    task automatic cs_end();
        tick(H);
        spi_cs_n = 1'b1;
        tick(H);
    endtask

    // Host sends one byte, samples MISO before each rising edge, checks it against miso_q.
    task automatic xfer_byte(input logic [7:0] b, input bit keep_rx);
        logic [7:0] got;
        logic [7:0] exp_b;
        if (keep_rx) rx_q.push_back(b);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            tick(H);
            got[i] = spi_miso;
            if (i == 0) ur_snap = ur_cnt;
            spi_sclk = 1'b1;
            tick(H);
            spi_sclk = 1'b0;
        end
        check("miso_oe", spi_miso_oe, 1);
        if (miso_q.size() != 0) begin
            exp_b = miso_q.pop_front();
            check("miso_byte", got, exp_b);
        end else begin
            check("miso_q_empty", miso_q.size() != 0, 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (rx_q.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        check("rx_drain", rx_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, spi_miso, 0);
        check({tag, "_miso_oe"}, spi_miso_oe, 0);
        check({tag, "_tx_ready"}, tx_ready, 1);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_underrun"}, underrun, 0);
    endtask

    initial begin
        int ur0;
        int ov0;
        int exp_ov;

        tick(3);
        check_reset_outputs("rst");
        reset = 1'b0;
        tick(3);

        // Single byte with a preloaded TX byte.
        write_tx(8'h3C);
        miso_q.push_back(8'h3C);
        check("t1_tx_ready_full", tx_ready, 0);
        cs_start();
        check("t1_busy", busy, 1);
        check("t1_tx_ready_loaded", tx_ready, 1);
        xfer_byte(8'hA5, 1'b1);
        cs_end();
        check("t1_busy_off", busy, 0);
        check("t1_oe_off", spi_miso_oe, 0);
        drain();

        // Two-byte burst with nothing queued.
        ur0 = ur_cnt;
        miso_q.push_back(8'hFF);
        miso_q.push_back(8'hFF);
        cs_start();
        xfer_byte(8'h01, 1'b1);
        xfer_byte(8'h02, 1'b1);
        check("t2_underruns", ur_snap - ur0, 2);
        cs_end();
        drain();

        // Back-to-back TX: second byte written while the first is shifting.
        write_tx(8'h11);
        miso_q.push_back(8'h11);
        miso_q.push_back(8'h22);
        ur0 = ur_cnt;
        cs_start();
        write_tx(8'h22);
        xfer_byte(8'h33, 1'b1);
        xfer_byte(8'h44, 1'b1);
        check("t3_underruns", ur_snap - ur0, 0);
        cs_end();
        drain();

        // Overrun with the consumer stalled.
        rx_ready = 1'b0;
        ov0 = ov_cnt;
        cs_start();
        for (int k = 0; k < 5; k++) begin
            miso_q.push_back(8'hFF);
`ifdef SPI_TARGET_RX_FIFO_EN
            xfer_byte(8'h10 + 8'(k), k < 4);
            exp_ov = (k == 4) ? 1 : 0;
`else
            xfer_byte(8'h10 + 8'(k), k == 0);
            exp_ov = k;
`endif
            check("t4_overruns", ov_cnt - ov0, exp_ov);
        end
        cs_end();
        check("t4_rx_valid", rx_valid, 1);
        check("t4_rx_head", rx_data, 8'h10);
        rx_ready = 1'b1;
        drain();

        // CS abort after four bits; holding register must survive.
        cs_start();
        write_tx(8'h96);
        miso_q.push_back(8'h96);
        for (int i = 7; i >= 4; i--) begin
            spi_mosi = i[0] ? 1'b1 : 1'b1;
            tick(H);
            spi_sclk = 1'b1;
            tick(H);
            spi_sclk = 1'b0;
        end
        tick(H);
        spi_cs_n = 1'b1;
        tick(4);
        check("t5_oe", spi_miso_oe, 0);
        check("t5_miso", spi_miso, 0);
        check("t5_busy", busy, 0);
        check("t5_rx_valid", rx_valid, 0);
        check("t5_hold_kept", tx_ready, 0);
        tick(H);
        cs_start();
        xfer_byte(8'h77, 1'b1);
        cs_end();
        drain();

        // Reset asserted during bit 5 of a byte.
        cs_start();
        write_tx(8'hC3);
        for (int i = 7; i >= 5; i--) begin
            spi_mosi = 1'b1;
            tick(H);
            spi_sclk = 1'b1;
            tick(H);
            if (i != 5) spi_sclk = 1'b0;
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(3);
        write_tx(8'h5A);
        miso_q.push_back(8'h5A);
        cs_start();
        xfer_byte(8'h5A, 1'b1);
        cs_end();
        drain();
        check("miso_q_left", miso_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
